// File: rtl/periph_read_arbiter.sv
// Round-robin read-return arbiter: grants one of R peripheral registers, drives the
// I/O read mux select, captures the chosen word and hands it to the CPU via valid/ready.
module periph_read_arbiter #(
  parameter int R = 2,
  parameter int T = 32,
  parameter int N = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req,
  input  logic [R*T-1:0] datain,
  input  logic           cpu_ready,
  output logic [R-1:0]   grant,
  output logic [N-1:0]   selection,
  output logic [T-1:0]   dataout,
  output logic           valid
);

  if (R > (1 << N)) begin : g_bad_sel_width
    $error("periph_read_arbiter: R=%0d does not fit in N=%0d select bits", R, N);
  end

  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] last;
  logic [N-1:0] pick;
  logic         hit;
  logic [R-1:0] pick_oh;
  logic [T-1:0] word [R];

  for (genvar i = 0; i < R; i++) begin : g_word
    assign word[i] = datain[i*T +: T];
  end

  // Slot o positions after the last served requester, wrapping at R.
  function automatic logic [N-1:0] rr_slot(input logic [N-1:0] base, input int o);
    int s;
    s = int'(base) + 1 + o;
    if (s >= R) s = s - R;
    return N'(s);
  endfunction

  // Scan from farthest to nearest so the nearest set request wins.
  always_comb begin
    pick = '0;
    hit  = 1'b0;
    for (int o = R-1; o >= 0; o--) begin
      if (req[rr_slot(last, o)]) begin
        pick = rr_slot(last, o);
        hit  = 1'b1;
      end
    end
  end

  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit) state_nxt = CAPTURE;
      CAPTURE: state_nxt = WAIT;
      WAIT:    if (valid && cpu_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // selection is left at k after acceptance so the read mux never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= '0;
      selection <= '0;
      dataout   <= '0;
      valid     <= 1'b0;
      last      <= N'(R-1);
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            grant     <= pick_oh;
            selection <= pick;
          end
        end
        CAPTURE: begin
          dataout <= word[selection];
          valid   <= 1'b1;
        end
        WAIT: begin
          if (valid && cpu_ready) begin
            valid <= 1'b0;
            grant <= '0;
            last  <= selection;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_read_arbiter.sv
// Bench for periph_read_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_periph_read_arbiter;
  localparam int R = 2;
  localparam int T = 32;
  localparam int N = 1;

  logic           clk;
  logic           rst_n;
  logic [R-1:0]   req;
  logic [R*T-1:0] datain;
  logic           cpu_ready;
  logic [R-1:0]   grant;
  logic [N-1:0]   selection;
  logic [T-1:0]   dataout;
  logic           valid;

  int n_chk  = 0;
  int n_fail = 0;

  periph_read_arbiter #(.R(R), .T(T), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .datain(datain), .cpu_ready(cpu_ready),
    .grant(grant), .selection(selection), .dataout(dataout), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Transaction-level model: m_k = requester being served (-1 none),
  // m_age = 0 on the grant cycle, 1 once the word is held for the CPU.
  int           m_k    = -1;
  int           m_age  = 0;
  int           m_last = R-1;
  int           m_sel  = 0;
  logic [T-1:0] m_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = -1; m_age = 0; m_last = R-1; m_sel = 0; m_data = '0;
    end else if (m_k < 0) begin
      for (int i = 1; i <= R; i++) begin
        if (m_k < 0 && req[(m_last + i) % R]) begin
          m_k   = (m_last + i) % R;
          m_sel = m_k;
          m_age = 0;
        end
      end
    end else if (m_age == 0) begin
      m_data = datain[m_k*T +: T];
      m_age  = 1;
    end else if (cpu_ready) begin
      m_last = m_k;
      m_k    = -1;
    end
  end

  always @(negedge clk) begin
    chk("grant",     64'(grant),     (m_k >= 0) ? (64'd1 << m_k) : 64'd0);
    chk("selection", 64'(selection), 64'(m_sel));
    chk("valid",     64'(valid),     64'(m_k >= 0 && m_age >= 1));
    chk("dataout",   64'(dataout),   64'(m_data));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; cpu_ready = 1'b0;
    datain = {32'hBBBB_0002, 32'hAAAA_0001};
    tick; tick;
    rst_n = 1'b1;

    // reset then idle
    for (int i = 0; i < 10; i++) begin
      chk("idle_grant", 64'(grant), 64'h0);
      chk("idle_valid", 64'(valid), 64'h0);
      chk("idle_data",  64'(dataout), 64'h0);
      chk("idle_sel",   64'(selection), 64'h0);
      tick;
    end

    // single request
    req = 2'b01; cpu_ready = 1'b1;
    tick; req = '0;
    chk("single_grant", 64'(grant), 64'h1);
    tick;
    chk("single_valid", 64'(valid), 64'h1);
    chk("single_data",  64'(dataout), 64'hAAAA_0001);
    tick;
    chk("single_done_valid", 64'(valid), 64'h0);
    chk("single_done_grant", 64'(grant), 64'h0);
    chk("single_hold_data",  64'(dataout), 64'hAAAA_0001);

    // contention after reset
    rst_n = 1'b0; tick; rst_n = 1'b1;
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      tick;
      chk("cont_grant", 64'(grant), 64'd1 << (j % 2));
      chk("cont_sel",   64'(selection), 64'(j % 2));
      chk("model_k",    64'(m_k), 64'(j % 2));
      tick;
      chk("cont_data",  64'(dataout), (j % 2) ? 64'hBBBB_0002 : 64'hAAAA_0001);
      tick;
      chk("cont_idle",  64'(grant), 64'h0);
    end

    // backpressure
    req = 2'b10; cpu_ready = 1'b0;
    tick; req = '0;
    chk("bp_grant", 64'(grant), 64'h2);
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(valid), 64'h1);
      chk("bp_data",  64'(dataout), 64'hBBBB_0002);
      chk("bp_grant_hold", 64'(grant), 64'h2);
      if (i == 0) req = 2'b01;
      tick;
    end
    cpu_ready = 1'b1;
    tick;
    chk("bp_release_valid", 64'(valid), 64'h0);
    chk("bp_release_grant", 64'(grant), 64'h0);
    chk("bp_release_sel",   64'(selection), 64'h1);
    tick; req = '0;
    chk("bp_next_grant", 64'(grant), 64'h1);
    tick;
    chk("bp_next_data", 64'(dataout), 64'hAAAA_0001);
    tick;

    // request withdrawn during wait
    req = 2'b10; cpu_ready = 1'b0;
    tick; req = '0;
    chk("wd_grant", 64'(grant), 64'h2);
    tick; tick;
    chk("wd_wait_valid", 64'(valid), 64'h1);
    cpu_ready = 1'b1;
    tick;
    chk("wd_done", 64'(valid), 64'h0);
    req = 2'b11;
    tick; req = '0;
    chk("wd_next_grant", 64'(grant), 64'h1);
    tick; tick;

    // reset during wait
    req = 2'b10; cpu_ready = 1'b0;
    tick; req = '0;
    tick;
    chk("rst_pre_valid", 64'(valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_data",  64'(dataout), 64'h0);
    tick;
    rst_n = 1'b1; req = 2'b11;
    tick; req = '0;
    chk("rst_first_grant", 64'(grant), 64'h1);
    cpu_ready = 1'b1;
    tick; tick;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      req       = R'($urandom);
      cpu_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < R; i++) datain[i*T +: T] = T'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0; tick; rst_n = 1'b1;
      end
      tick;
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
